// File: rtl/rr_reg_arbiter.sv
// -----------------------------------------------------------------------------
// rr_reg_arbiter
//
// Round-robin arbiter and sequencer in front of a single shared capture
// register. N_REQ producers compete for the register. One owner is granted at a
// time. Each cycle in which the owner keeps its request high is a transfer: the
// owner's data is captured into dout and dout_vld pulses.
//
// The grant is released in two cases:
//   - the owner drops its request (no transfer on that edge), or
//   - the owner completes MAX_HOLD consecutive transfers (the last transfer is
//     still captured on that edge).
// On release, the rotation point moves to the requester after the old owner.
// Arbitration then runs again on the same edge, so a waiting requester takes
// over with no idle cycle in between.
//
// Parameters:
//   N_REQ    number of requesters (>= 2, any value)
//   DW       data width per requester
//   MAX_HOLD transfers allowed per grant before forced rotation (>= 1)
//
// Ports:
//   clk       clock; all state updates on the rising edge
//   rst       synchronous, active-high reset
//   req       per-requester request, level-sensitive
//   din       packed data; requester i occupies din[i*DW +: DW]
//   gnt       registered one-hot grant; all-zero when idle
//   gnt_id    index of the current owner; 0 when idle
//   dout      shared capture register
//   dout_vld  high for one cycle per captured transfer
//
// Optional build macro:
//   RR_REG_ARBITER_ASSERT_EN  compiles in simulation-time immediate assertions
//                             on the grant, counter and output invariants.
// -----------------------------------------------------------------------------
module rr_reg_arbiter #(
    parameter int N_REQ    = 4,
    parameter int DW       = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*DW-1:0]        din,
    output logic [N_REQ-1:0]           gnt,
    output logic [$clog2(N_REQ)-1:0]   gnt_id,
    output logic [DW-1:0]              dout,
    output logic                       dout_vld
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_HOLD + 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]       state;
    logic [IW-1:0]    ptr;
    logic [CW-1:0]    cnt;

    logic [IW-1:0]    next_id;
    logic [IW-1:0]    arb_base;
    logic [IW-1:0]    win_id;
    logic             win_vld;
    logic [N_REQ-1:0] win_onehot;
    logic             xfer;
    logic             hold_done;
    logic             release_gnt;
    logic [DW-1:0]    owner_data;

    // Index arithmetic modulo N_REQ. N_REQ need not be a power of two, so the
    // natural IW-bit wrap cannot be relied on.
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_REQ)
            s = s - N_REQ;
        return IW'(s);
    endfunction

    assign next_id = wrap_add(gnt_id, 1);

    // When the grant is released, the scan starts after the outgoing owner.
    // That is the value ptr takes on the same edge. Using it directly avoids
    // waiting a cycle for the register. In IDLE the stored ptr is already
    // current.
    assign arb_base = (state == GRANT) ? next_id : ptr;

    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!win_vld && req[wrap_add(arb_base, k)]) begin
                win_vld = 1'b1;
                win_id  = wrap_add(arb_base, k);
            end
        end
    end

    assign win_onehot  = {{(N_REQ-1){1'b0}}, 1'b1} << win_id;

    assign xfer        = (state == GRANT) && req[gnt_id];
    // The transfer on this edge is the MAX_HOLD-th one for this grant.
    assign hold_done   = (cnt == CW'(MAX_HOLD - 1));
    assign release_gnt = (state == GRANT) && (!req[gnt_id] || hold_done);
    assign owner_data  = din[int'(gnt_id)*DW +: DW];

    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then updates from pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            cnt      <= '0;
            gnt      <= '0;
            gnt_id   <= '0;
            dout     <= '0;
            dout_vld <= 1'b0;
        end else begin
            dout_vld <= xfer;
            if (xfer)
                dout <= owner_data;

            case (state)
                IDLE: begin
                    if (win_vld) begin
                        gnt    <= win_onehot;
                        gnt_id <= win_id;
                        cnt    <= '0;
                        state  <= GRANT;
                    end
                end
                GRANT: begin
                    if (xfer)
                        cnt <= cnt + CW'(1);
                    if (release_gnt) begin
                        ptr <= next_id;
                        cnt <= '0;
                        if (win_vld) begin
                            // A sole requester at its hold limit wins again here,
                            // but the rotation point has still advanced.
                            gnt    <= win_onehot;
                            gnt_id <= win_id;
                        end else begin
                            gnt    <= '0;
                            gnt_id <= '0;
                            state  <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    gnt_id <= '0;
                end
            endcase
        end
    end

`ifdef RR_REG_ARBITER_ASSERT_EN
    logic             rst_q;
    logic             xfer_q;
    logic [N_REQ-1:0] id_onehot;

    always_ff @(posedge clk) begin
        rst_q  <= rst;
        xfer_q <= xfer & ~rst;
    end

    assign id_onehot = (gnt == '0) ? '0 : ({{(N_REQ-1){1'b0}}, 1'b1} << gnt_id);

    // The checks sample register values left by the previous edge. They are
    // skipped until the first reset edge has defined the history flags.
    always @(posedge clk) begin
        if (!$isunknown(rst_q)) begin
            a_onehot: assert ($onehot0(gnt))
                $info("gnt onehot0 ok");
            else
                $error("gnt not onehot0: %b at %0t", gnt, $time);

            a_gnt_id: assert (gnt == id_onehot && (gnt != '0 || gnt_id == '0))
                $info("gnt_id matches gnt");
            else
                $error("gnt_id %0d does not match gnt %b at %0t", gnt_id, gnt, $time);

            a_cnt: assert (int'(cnt) <= MAX_HOLD)
                $info("cnt in range");
            else
                $error("cnt %0d exceeds MAX_HOLD at %0t", cnt, $time);

            a_vld: assert (!dout_vld || xfer_q)
                $info("dout_vld backed by owner request");
            else
                $error("dout_vld without owner request at %0t", $time);

            if (rst_q) begin
                a_rst: assert (gnt == '0 && dout == '0 && !dout_vld)
                    $info("reset state ok");
                else
                    $error("outputs not cleared after reset at %0t", $time);
            end
        end
    end
`endif

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_reg_arbiter
//
// Self-checking bench for rr_reg_arbiter with N_REQ=4, DW=8, MAX_HOLD=4.
//
// The first part is a table of hand-computed vectors covering reset and a
// single-requester burst. Hand-written sequences follow for the rotation,
// hold-limit, handover and mid-burst reset corner cases. The last part is
// randomized traffic checked against a reference model. The model tracks the
// owner as an integer, with -1 meaning idle.
// -----------------------------------------------------------------------------
module tb_rr_reg_arbiter;

    localparam int N_REQ    = 4;
    localparam int DW       = 8;
    localparam int MAX_HOLD = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [N_REQ-1:0]      req = '0;
    logic [N_REQ*DW-1:0]   din = '0;
    logic [N_REQ-1:0]      gnt;
    logic [1:0]            gnt_id;
    logic [DW-1:0]         dout;
    logic                  dout_vld;

    rr_reg_arbiter #(
        .N_REQ    (N_REQ),
        .DW       (DW),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .din      (din),
        .gnt      (gnt),
        .gnt_id   (gnt_id),
        .dout     (dout),
        .dout_vld (dout_vld)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int            m_owner = -1;
    int            m_ptr   = 0;
    int            m_cnt   = 0;
    logic [DW-1:0] m_dout  = '0;
    logic          m_vld   = 1'b0;

    function automatic int pick(input int base, input logic [N_REQ-1:0] r);
        for (int k = 0; k < N_REQ; k++)
            if (r[(base + k) % N_REQ])
                return (base + k) % N_REQ;
        return -1;
    endfunction

    task automatic model_edge(input logic r, input logic [N_REQ-1:0] q, input logic [N_REQ*DW-1:0] d);
        int  o;
        int  w;
        bit  rel;
        if (r) begin
            m_owner = -1; m_ptr = 0; m_cnt = 0; m_dout = '0; m_vld = 1'b0;
        end else begin
            m_vld = 1'b0;
            if (m_owner < 0) begin
                w = pick(m_ptr, q);
                if (w >= 0) begin
                    m_owner = w;
                    m_cnt = 0;
                end
            end else begin
                o = m_owner;
                if (q[o]) begin
                    m_dout = d[o*DW +: DW];
                    m_vld  = 1'b1;
                    m_cnt++;
                    rel = (m_cnt == MAX_HOLD);
                end else begin
                    rel = 1'b1;
                end
                if (rel) begin
                    m_ptr = (o + 1) % N_REQ;
                    m_cnt = 0;
                    m_owner = pick(m_ptr, q);
                end
            end
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_gnt"},    32'(gnt),      (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
        check({tag, "_gnt_id"}, 32'(gnt_id),   (m_owner < 0) ? 32'd0 : 32'(m_owner));
        check({tag, "_dout"},   32'(dout),     32'(m_dout));
        check({tag, "_vld"},    32'(dout_vld), 32'(m_vld));
    endtask

    // Drive inputs for the next edge, advance the model, then sample just after the edge.
    task automatic edge_step(input logic r, input logic [N_REQ-1:0] q, input logic [N_REQ*DW-1:0] d);
        rst = r;
        req = q;
        din = d;
        model_edge(r, q, d);
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic                rst;
        logic [N_REQ-1:0]    req;
        logic [N_REQ*DW-1:0] din;
        logic [N_REQ-1:0]    gnt;
        logic [1:0]          gnt_id;
        logic [DW-1:0]       dout;
        logic                vld;
    } vec_t;

    vec_t vecs [11];

    localparam logic [31:0] DIN_FF  = 32'hFFFF_FFFF;
    localparam logic [31:0] DIN_A5  = 32'h0000_00A5;
    localparam logic [31:0] DIN_INC = 32'h1312_1110;
    localparam logic [31:0] DIN_AB  = 32'h0000_B1A0;

    initial begin
        //           rst   req    din      gnt    id    dout   vld
        vecs[0]  = '{1'b1, 4'hF, DIN_FF,  4'h0, 2'd0, 8'h00, 1'b0};  // reset edge 1
        vecs[1]  = '{1'b1, 4'hF, DIN_FF,  4'h0, 2'd0, 8'h00, 1'b0};  // reset edge 2
        vecs[2]  = '{1'b0, 4'h1, DIN_A5,  4'h1, 2'd0, 8'h00, 1'b0};  // grant, no transfer yet
        vecs[3]  = '{1'b0, 4'h1, DIN_A5,  4'h1, 2'd0, 8'hA5, 1'b1};  // transfer 1
        vecs[4]  = '{1'b0, 4'h1, DIN_A5,  4'h1, 2'd0, 8'hA5, 1'b1};  // transfer 2
        vecs[5]  = '{1'b0, 4'h1, DIN_A5,  4'h1, 2'd0, 8'hA5, 1'b1};  // transfer 3
        vecs[6]  = '{1'b0, 4'h0, DIN_A5,  4'h0, 2'd0, 8'hA5, 1'b0};  // drop: idle, dout holds
        vecs[7]  = '{1'b0, 4'h0, 32'h0,   4'h0, 2'd0, 8'hA5, 1'b0};  // stay idle
        vecs[8]  = '{1'b0, 4'hF, 32'h0,   4'h2, 2'd1, 8'hA5, 1'b0};  // ptr=1, so 1 wins
        vecs[9]  = '{1'b0, 4'hF, DIN_INC, 4'h2, 2'd1, 8'h11, 1'b1};  // owner 1 transfers
        vecs[10] = '{1'b1, 4'hF, DIN_INC, 4'h0, 2'd0, 8'h00, 1'b0};  // reset mid-grant

        #2;
        for (int i = 0; i < 11; i++) begin
            edge_step(vecs[i].rst, vecs[i].req, vecs[i].din);
            check($sformatf("vec%0d_gnt", i),    32'(gnt),      32'(vecs[i].gnt));
            check($sformatf("vec%0d_gnt_id", i), 32'(gnt_id),   32'(vecs[i].gnt_id));
            check($sformatf("vec%0d_dout", i),   32'(dout),     32'(vecs[i].dout));
            check($sformatf("vec%0d_vld", i),    32'(dout_vld), 32'(vecs[i].vld));
        end

        // ---- full contention: owners rotate 0,1,2,3,0 with no vld gap ----
        edge_step(1'b1, 4'h0, 32'h0);
        edge_step(1'b0, 4'hF, DIN_INC);
        check_model("rot_first");
        check("rot_first_gnt", 32'(gnt), 32'h1);
        for (int j = 0; j < 20; j++) begin
            edge_step(1'b0, 4'hF, DIN_INC);
            check_model("rot");
            check($sformatf("rot%0d_dout", j), 32'(dout),     32'h10 + 32'((j / 4) % 4));
            check($sformatf("rot%0d_vld", j),  32'(dout_vld), 32'h1);
            check($sformatf("rot%0d_gnt", j),  32'(gnt),      32'd1 << (((j + 1) / 4) % 4));
        end

        // ---- sole requester across forced releases ----
        edge_step(1'b1, 4'h0, 32'h0);
        for (int j = 0; j < 12; j++) begin
            edge_step(1'b0, 4'h4, 32'h00C3_0000);
            check_model("sole");
            check($sformatf("sole%0d_gnt", j), 32'(gnt), 32'h4);
            if (j > 0)
                check($sformatf("sole%0d_vld", j), 32'(dout_vld), 32'h1);
        end
        edge_step(1'b0, 4'h0, 32'h0);
        check_model("sole_drop");
        edge_step(1'b0, 4'hF, 32'h0);
        check("sole_ptr3_gnt", 32'(gnt), 32'h8);  // rotation point ended at 3

        // ---- owner drop handover ----
        edge_step(1'b1, 4'h0, 32'h0);
        edge_step(1'b0, 4'h3, DIN_AB);   // grant 0
        edge_step(1'b0, 4'h3, DIN_AB);   // transfer 1
        edge_step(1'b0, 4'h3, DIN_AB);   // transfer 2
        check_model("hand_pre");
        edge_step(1'b0, 4'h2, DIN_AB);   // owner 0 drops
        check_model("hand_sw");
        check("hand_sw_gnt",  32'(gnt),      32'h2);
        check("hand_sw_vld",  32'(dout_vld), 32'h0);
        check("hand_sw_dout", 32'(dout),     32'hA0);
        edge_step(1'b0, 4'h2, DIN_AB);
        check("hand_b1_dout", 32'(dout),     32'hB1);
        check("hand_b1_vld",  32'(dout_vld), 32'h1);

        // ---- reset during owner 2's second transfer ----
        edge_step(1'b1, 4'h0, 32'h0);
        edge_step(1'b0, 4'hF, DIN_INC);                  // grant 0
        for (int j = 0; j < 9; j++)
            edge_step(1'b0, 4'hF, DIN_INC);              // owner0 x4, owner1 x4, owner2 x1
        check("mid_pre_gnt", 32'(gnt), 32'h4);
        edge_step(1'b1, 4'hF, DIN_INC);                  // reset on owner 2's second transfer
        check_model("mid_rst");
        check("mid_rst_gnt",  32'(gnt),      32'h0);
        check("mid_rst_dout", 32'(dout),     32'h0);
        check("mid_rst_vld",  32'(dout_vld), 32'h0);
        edge_step(1'b0, 4'hF, DIN_INC);
        check("mid_after_gnt", 32'(gnt), 32'h1);

        // ---- randomized traffic against the model ----
        edge_step(1'b1, 4'h0, 32'h0);
        begin
            logic [N_REQ-1:0] rq;
            rq = '0;
            for (int j = 0; j < 400; j++) begin
                if ($urandom_range(0, 3) == 0)
                    rq = N_REQ'($urandom_range(0, 15));
                edge_step(($urandom_range(0, 63) == 0), rq, $urandom);
                check_model($sformatf("rnd%0d", j));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
